fb_mem_arbiter: RTL and testbench

- Shares the single-port on-chip Game Boy framebuffer RAM (160x144 pixels, one byte per pixel) between three requesters.
- Requesters: the VGA scanout line prefetcher (read-only), the PPU pixel writer (write-only) and the Nios/Avalon CPU bridge (read/write).
- Grants at most one RAM access per clock: VGA has fixed priority, PPU and CPU share round-robin, and an anti-starvation counter bounds their wait.
- Sits between the PPU, the VGA controller and the SoC bridge, in front of the framebuffer RAM.

---
 rtl/fb_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_fb_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA fixed priority, PPU/CPU round-robin with a starvation bound.
// Optional grant counters are built when FB_ARB_STATS_EN is defined.
module fb_mem_arbiter #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 23040,
    parameter int unsigned STARVE_MAX = 8,
    localparam int unsigned STAT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic [DATA_W-1:0] ppu_wdata,
    output logic              ppu_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [STAT_W-1:0] stat_vga,
    output logic [STAT_W-1:0] stat_ppu,
    output logic [STAT_W-1:0] stat_cpu
);

    localparam int unsigned CNT_W = 8;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  STARVE_C = CNT_W'(STARVE_MAX);

    logic             rr_ptr;       // 0: PPU preferred, 1: CPU preferred
    logic [CNT_W-1:0] starve_cnt;
    logic             rd_oor;
    logic             shared_req;
    logic             starved;
    logic             pick_cpu;
    logic             wr_req;
    logic             addr_ok;

    // Grant decision and RAM port mux; every grant is held low during reset.
    always_comb begin
        shared_req = ppu_req | cpu_req;
        starved    = shared_req && (starve_cnt == STARVE_C);
        pick_cpu   = cpu_req && (!ppu_req || rr_ptr);
        vga_gnt    = reset_n && vga_req && !starved;
        ppu_gnt    = reset_n && shared_req && !vga_gnt && !pick_cpu;
        cpu_gnt    = reset_n && shared_req && !vga_gnt && pick_cpu;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_req     = 1'b0;
        if (vga_gnt) begin
            mem_addr = vga_addr;
        end else if (ppu_gnt) begin
            mem_addr  = ppu_addr;
            mem_wdata = ppu_wdata;
            wr_req    = 1'b1;
        end else if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            wr_req    = cpu_we;
        end
        addr_ok = (mem_addr < DEPTH_A);
        mem_we  = wr_req && addr_ok;
    end

    // Round-robin pointer, starvation counter and read-return tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
            vga_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            rd_oor     <= 1'b0;
        end else begin
            if (ppu_gnt || cpu_gnt) begin
                rr_ptr <= ~rr_ptr;
            end
            if (ppu_gnt || cpu_gnt || !shared_req) begin
                starve_cnt <= '0;
            end else if (vga_gnt && (starve_cnt != STARVE_C)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
            vga_rvalid <= vga_gnt;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            rd_oor     <= !addr_ok;
        end
    end

    // Out-of-range reads return zero, and idle read ports are forced to zero.
    assign vga_rdata = (vga_rvalid && !rd_oor) ? mem_rdata : '0;
    assign cpu_rdata = (cpu_rvalid && !rd_oor) ? mem_rdata : '0;

`ifdef FB_ARB_STATS_EN
    // Saturating per-port grant counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_vga <= '0;
            stat_ppu <= '0;
            stat_cpu <= '0;
        end else begin
            if (vga_gnt && (stat_vga != '1)) begin
                stat_vga <= stat_vga + STAT_W'(1);
            end
            if (ppu_gnt && (stat_ppu != '1)) begin
                stat_ppu <= stat_ppu + STAT_W'(1);
            end
            if (cpu_gnt && (stat_cpu != '1)) begin
                stat_cpu <= stat_cpu + STAT_W'(1);
            end
        end
    end
`else
    assign stat_vga = '0;
    assign stat_ppu = '0;
    assign stat_cpu = '0;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a small registered-read RAM model.
module tb_fb_mem_arbiter;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 23040;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              vga_req, ppu_req, cpu_req, cpu_we;
    logic [ADDR_W-1:0] vga_addr, ppu_addr, cpu_addr;
    logic [DATA_W-1:0] ppu_wdata, cpu_wdata;
    logic              vga_gnt, ppu_gnt, cpu_gnt;
    logic              vga_rvalid, cpu_rvalid;
    logic [DATA_W-1:0] vga_rdata, cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       stat_vga, stat_ppu, stat_cpu;
    logic              preload;
    logic [DATA_W-1:0] ram [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata), .ppu_gnt(ppu_gnt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_vga(stat_vga), .stat_ppu(stat_ppu), .stat_cpu(stat_cpu)
    );

    // RAM: one-cycle read latency; out-of-range reads return junk the arbiter must mask.
    always @(posedge clk) begin
        if (preload) begin
            ram[16] <= 8'hA5;
            ram[32] <= 8'h3C;
        end else if (mem_we && (mem_addr < ADDR_W'(DEPTH))) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= (mem_addr < ADDR_W'(DEPTH)) ? ram[mem_addr] : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        preload   = 1'b1;
        vga_req   = 1'b1; vga_addr = 15'h0020;
        ppu_req   = 1'b1; ppu_addr = 15'h0100; ppu_wdata = 8'h77;
        cpu_req   = 1'b1; cpu_we   = 1'b1; cpu_addr = 15'h0200; cpu_wdata = 8'h55;

        // Reset with every request asserted.
        @(negedge clk);
        check("rst_vga_gnt", 32'(vga_gnt), 32'd0);
        check("rst_ppu_gnt", 32'(ppu_gnt), 32'd0);
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rvalid", 32'({vga_rvalid, cpu_rvalid}), 32'd0);

        cyc(); preload = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        check("rel_vga_gnt", 32'(vga_gnt), 32'd1);
        check("rel_ppu_gnt", 32'(ppu_gnt), 32'd0);
        check("rel_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rel_mem_addr", 32'(mem_addr), 32'h20);
        check("rel_stat", 32'({stat_vga, stat_ppu} | 32'(stat_cpu)), 32'd0);

        cyc(); vga_req = 1'b0; ppu_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("vga_rvalid", 32'(vga_rvalid), 32'd1);
        check("vga_rdata", 32'(vga_rdata), 32'h3C);
        check("vga_ret_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

        // PPU and CPU writes alternate starting with PPU.
        for (int k = 0; k < 4; k++) begin
            cyc(); ppu_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
            @(negedge clk);
            check("rr_ppu_gnt", 32'(ppu_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_cpu_gnt", 32'(cpu_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
            check("rr_mem_we", 32'(mem_we), 32'd1);
            check("rr_mem_addr", 32'(mem_addr), (k % 2 == 0) ? 32'h100 : 32'h200);
            check("rr_mem_wdata", 32'(mem_wdata), (k % 2 == 0) ? 32'h77 : 32'h55);
            check("rr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        end
        cyc(); ppu_req = 1'b0; cpu_req = 1'b0;

        // CPU read with single-cycle return.
        cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
        @(negedge clk);
        check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("rd_mem_addr", 32'(mem_addr), 32'h10);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        check("rd_rvalid_n", 32'(cpu_rvalid), 32'd0);
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid_n1", 32'(cpu_rvalid), 32'd1);
        check("rd_rdata_n1", 32'(cpu_rdata), 32'hA5);
        check("rd_vga_rvalid", 32'(vga_rvalid), 32'd0);
        cyc();
        @(negedge clk);
        check("rd_rvalid_n2", 32'(cpu_rvalid), 32'd0);
        check("rd_rdata_n2", 32'(cpu_rdata), 32'd0);

        // Starvation: VGA holds 8 cycles, then the CPU pre-empts it.
        cyc(); vga_req = 1'b1; vga_addr = 15'h0020; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stv_vga_gnt", 32'(vga_gnt), 32'd1);
            check("stv_cpu_gnt", 32'(cpu_gnt), 32'd0);
            cyc();
        end
        @(negedge clk);
        check("stv9_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("stv9_vga_gnt", 32'(vga_gnt), 32'd0);
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        check("stv10_vga_gnt", 32'(vga_gnt), 32'd1);
        check("stv10_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("stv10_cpu_rdata", 32'(cpu_rdata), 32'hA5);
        cyc(); cpu_req = 1'b1;
        @(negedge clk);
        check("stv_cleared_vga", 32'(vga_gnt), 32'd1);
        check("stv_cleared_cpu", 32'(cpu_gnt), 32'd0);
        cyc(); vga_req = 1'b0; cpu_req = 1'b0;

        // Depth boundary: writes at 23040 dropped, 23039 kept, read of 23040 returns 0.
        cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd23040; cpu_wdata = 8'h99;
        @(negedge clk);
        check("oor_wr_gnt", 32'(cpu_gnt), 32'd1);
        check("oor_wr_we", 32'(mem_we), 32'd0);
        cyc(); cpu_addr = 15'd23039;
        @(negedge clk);
        check("last_wr_we", 32'(mem_we), 32'd1);
        check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        cyc(); cpu_we = 1'b0; cpu_addr = 15'd23040;
        @(negedge clk);
        check("oor_rd_gnt", 32'(cpu_gnt), 32'd1);
        check("oor_rd_we", 32'(mem_we), 32'd0);
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        check("oor_rd_rvalid", 32'(cpu_rvalid), 32'd1);
        check("oor_rd_rdata", 32'(cpu_rdata), 32'd0);

        // Reset right after a VGA grant drops the pending return.
        cyc(); vga_req = 1'b1; vga_addr = 15'h0020;
        @(negedge clk);
        check("mid_vga_gnt", 32'(vga_gnt), 32'd1);
        cyc(); reset_n = 1'b0; vga_req = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", 32'(vga_rvalid), 32'd0);
        check("mid_rst_rdata", 32'(vga_rdata), 32'd0);
        cyc(); reset_n = 1'b1;
        @(negedge clk);
        check("mid_rel_rvalid", 32'({vga_rvalid, cpu_rvalid}), 32'd0);
        check("mid_rel_stat", 32'(stat_vga), 32'd0);
        cyc();
        @(negedge clk);
        check("mid_rel_rvalid2", 32'(vga_rvalid), 32'd0);

        // Grant counters after one VGA grant.
        cyc(); vga_req = 1'b1;
        @(negedge clk);
        check("st_vga_gnt", 32'(vga_gnt), 32'd1);
        cyc(); vga_req = 1'b0;
        @(negedge clk);
`ifdef FB_ARB_STATS_EN
        check("st_vga", 32'(stat_vga), 32'd1);
`else
        check("st_vga", 32'(stat_vga), 32'd0);
`endif
        check("st_ppu", 32'(stat_ppu), 32'd0);
        check("st_cpu", 32'(stat_cpu), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
